// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB-Lite transfer constants and arbiter state type
// Contents: HTRANS_* encodings, arb_state_e, is_request() helper.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_e;

    // BUSY keeps a burst alive but is not a request for the bus.
    function automatic logic is_request(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_rr_arb.sv
// rtl/ahb_rr_arb.sv - request vector to one-hot grant
// Build option: AHB_ARB_RR_EN selects round-robin (pointer = last granted index);
//               otherwise fixed priority with master 0 highest and no state.
// Ports: clk/rst clock and async active-high reset; req request vector;
//        advance grant is being taken this cycle; grant one-hot winner.
module ahb_rr_arb #(
    parameter int N_MASTERS = 2,
    parameter int IDX_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_MASTERS-1:0] req,
    input  logic                 advance,
    output logic [N_MASTERS-1:0] grant
);

`ifdef AHB_ARB_RR_EN
    logic [IDX_WIDTH-1:0] ptr;
    logic [IDX_WIDTH-1:0] grant_idx;

    // Search starts one past the last owner and wraps; first requester wins.
    always_comb begin
        int   start;
        logic found;
        grant = '0;
        found = 1'b0;
        start = 0;
        for (int off = 1; off <= N_MASTERS; off++) begin
            start = int'(ptr) + off;
            if (start >= N_MASTERS) begin
                start = start - N_MASTERS;
            end
            for (int i = 0; i < N_MASTERS; i++) begin
                if (!found && req[i] && (start == i)) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (grant[i]) begin
                grant_idx = IDX_WIDTH'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= grant_idx;
        end
    end
`else
    // Scan from the top so the lowest requesting index overwrites last.
    always_comb begin
        grant = '0;
        for (int i = N_MASTERS - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
            end
        end
    end

    logic unused_ok;
    assign unused_ok = ^{clk, rst, advance};
`endif

endmodule

// File: rtl/ahb_arb.sv
// rtl/ahb_arb.sv - AHB-Lite N-master to single-slave arbiter
// Build option: AHB_ARB_RR_EN enables round-robin arbitration in ahb_rr_arb.
// Ports: hclk_i/hrst_i clock and async active-high reset;
//        m_* per-master address/data phase inputs, m_hready_o, broadcast m_hrdata_o/m_hresp_o;
//        haddr_o..hwstrb_o, hsel_o, hmaster_o slave request; hrdata_i/hreadyout_i/hresp_i slave reply.
module ahb_arb #(
    parameter int N_MASTERS     = 2,
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int HMASTER_WIDTH = 3,
    localparam int STRB_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                            hclk_i,
    input  logic                            hrst_i,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0] m_haddr_i,
    input  logic [N_MASTERS*2-1:0]          m_htrans_i,
    input  logic [N_MASTERS-1:0]            m_hwrite_i,
    input  logic [N_MASTERS*3-1:0]          m_hsize_i,
    input  logic [N_MASTERS*4-1:0]          m_hprot_i,
    input  logic [N_MASTERS-1:0]            m_hmastlock_i,
    input  logic [N_MASTERS*DATA_WIDTH-1:0] m_hwdata_i,
    input  logic [N_MASTERS*STRB_WIDTH-1:0] m_hwstrb_i,
    output logic [N_MASTERS-1:0]            m_hready_o,
    output logic [DATA_WIDTH-1:0]           m_hrdata_o,
    output logic                            m_hresp_o,
    output logic [ADDR_WIDTH-1:0]           haddr_o,
    output logic [1:0]                      htrans_o,
    output logic                            hwrite_o,
    output logic [2:0]                      hsize_o,
    output logic [3:0]                      hprot_o,
    output logic                            hmastlock_o,
    output logic [DATA_WIDTH-1:0]           hwdata_o,
    output logic [STRB_WIDTH-1:0]           hwstrb_o,
    output logic                            hsel_o,
    output logic [HMASTER_WIDTH-1:0]        hmaster_o,
    input  logic [DATA_WIDTH-1:0]           hrdata_i,
    input  logic                            hreadyout_i,
    input  logic                            hresp_i
);
    import ahb_pkg::*;

    arb_state_e               state, state_next;
    logic [HMASTER_WIDTH-1:0] owner;
    logic [HMASTER_WIDTH-1:0] win_idx;
    logic [N_MASTERS-1:0]     req;
    logic [N_MASTERS-1:0]     grant;
    logic                     advance;

    logic [ADDR_WIDTH-1:0]    sel_haddr;
    logic [1:0]               sel_htrans;
    logic                     sel_hwrite;
    logic [2:0]               sel_hsize;
    logic [3:0]               sel_hprot;
    logic                     sel_lock;
    logic [DATA_WIDTH-1:0]    sel_hwdata;
    logic [STRB_WIDTH-1:0]    sel_hwstrb;

    always_comb begin
        req = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            req[i] = is_request(m_htrans_i[2*i +: 2]);
        end
    end

    assign advance = (state == ST_IDLE) && (|req);

    ahb_rr_arb #(
        .N_MASTERS (N_MASTERS),
        .IDX_WIDTH (HMASTER_WIDTH)
    ) u_rr_arb (
        .clk     (hclk_i),
        .rst     (hrst_i),
        .req     (req),
        .advance (advance),
        .grant   (grant)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (grant[i]) begin
                win_idx = HMASTER_WIDTH'(i);
            end
        end
    end

    always_ff @(posedge hclk_i or posedge hrst_i) begin
        if (hrst_i) begin
            state <= ST_IDLE;
            owner <= '0;
        end else begin
            state <= state_next;
            if (advance) begin
                owner <= win_idx;
            end
        end
    end

    // Owner is fixed outside IDLE, so the data-phase owner equals the
    // address-phase owner and one mux serves both phases.
    always_comb begin
        sel_haddr  = '0;
        sel_htrans = HTRANS_IDLE;
        sel_hwrite = 1'b0;
        sel_hsize  = '0;
        sel_hprot  = '0;
        sel_lock   = 1'b0;
        sel_hwdata = '0;
        sel_hwstrb = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (owner == HMASTER_WIDTH'(i)) begin
                sel_haddr  = m_haddr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_htrans = m_htrans_i[2*i +: 2];
                sel_hwrite = m_hwrite_i[i];
                sel_hsize  = m_hsize_i[3*i +: 3];
                sel_hprot  = m_hprot_i[4*i +: 4];
                sel_lock   = m_hmastlock_i[i];
                sel_hwdata = m_hwdata_i[i*DATA_WIDTH +: DATA_WIDTH];
                sel_hwstrb = m_hwstrb_i[i*STRB_WIDTH +: STRB_WIDTH];
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (|req) state_next = ST_ADDR;
            ST_ADDR: if (hreadyout_i) state_next = ST_DATA;
            ST_DATA: begin
                // Any live transfer (incl. BUSY) or a held lock keeps the bus.
                if (hreadyout_i && (sel_htrans == HTRANS_IDLE) && !sel_lock) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        haddr_o     = sel_haddr;
        hwrite_o    = sel_hwrite;
        hsize_o     = sel_hsize;
        hprot_o     = sel_hprot;
        hmastlock_o = sel_lock;
        hwdata_o    = sel_hwdata;
        hwstrb_o    = sel_hwstrb;
        htrans_o    = HTRANS_IDLE;
        hsel_o      = 1'b0;
        if (state != ST_IDLE) begin
            hsel_o   = 1'b1;
            htrans_o = sel_htrans;
        end
        // First ERROR cycle: cancel whatever the owner pipelined behind it.
        if (hresp_i && !hreadyout_i) begin
            htrans_o = HTRANS_IDLE;
        end
    end

    always_comb begin
        m_hready_o = '1;
        for (int i = 0; i < N_MASTERS; i++) begin
            if ((state != ST_IDLE) && (owner == HMASTER_WIDTH'(i))) begin
                m_hready_o[i] = hreadyout_i;
            end else begin
                m_hready_o[i] = ~req[i];
            end
        end
        if (hrst_i) begin
            m_hready_o = '1;
        end
    end

    assign m_hrdata_o = hrdata_i;
    assign m_hresp_o  = hresp_i;
    assign hmaster_o  = owner;

endmodule
